// File: rtl/bus_arbiter_if.sv
// Bundle of the two master ports and the shared peripheral bus port of bus_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface bus_arbiter_if;
    logic        m0_req_i;
    logic        m0_we_i;
    logic [3:0]  m0_be_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_wdata_i;
    logic        m0_gnt_o;
    logic        m0_rvalid_o;
    logic [31:0] m0_rdata_o;

    logic        m1_req_i;
    logic        m1_we_i;
    logic [3:0]  m1_be_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_wdata_i;
    logic        m1_gnt_o;
    logic        m1_rvalid_o;
    logic [31:0] m1_rdata_o;

    logic        s_req_o;
    logic        s_we_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_wdata_o;
    logic        s_gnt_i;
    logic        s_rvalid_i;
    logic [31:0] s_rdata_i;

    logic        err_o;

    modport slave (
        input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        output s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o,
        input  s_gnt_i, s_rvalid_i, s_rdata_i,
        output err_o
    );

    modport master (
        output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        input  s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o,
        output s_gnt_i, s_rvalid_i, s_rdata_i,
        input  err_o
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto a shared pipelined bus; an owner FIFO of
// DEPTH entries routes each in-order response back to the master that issued it.
module bus_arbiter #(
    parameter int DEPTH = 2
) (
    input logic         clk_i,
    input logic         rst_i,
    bus_arbiter_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DEPTH-1:0] owner;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             last_gnt;
    logic             err;

    logic any_req;
    logic winner;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // On a tie the master not named by last_gnt wins; otherwise the lone requester (m0 when idle).
    assign any_req = bus.m0_req_i | bus.m1_req_i;
    assign winner  = (bus.m0_req_i & bus.m1_req_i) ? ~last_gnt : bus.m1_req_i;
    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign push    = bus.s_req_o & bus.s_gnt_i;
    assign pop     = bus.s_rvalid_i & ~empty;
    assign head    = owner[rd_ptr];

    assign bus.s_req_o   = any_req & ~full;
    assign bus.s_we_o    = winner ? bus.m1_we_i    : bus.m0_we_i;
    assign bus.s_be_o    = winner ? bus.m1_be_i    : bus.m0_be_i;
    assign bus.s_addr_o  = winner ? bus.m1_addr_i  : bus.m0_addr_i;
    assign bus.s_wdata_o = winner ? bus.m1_wdata_i : bus.m0_wdata_i;

    assign bus.m0_gnt_o    = push & ~winner;
    assign bus.m1_gnt_o    = push & winner;
    assign bus.m0_rvalid_o = pop & ~head;
    assign bus.m1_rvalid_o = pop & head;
    assign bus.m0_rdata_o  = bus.s_rdata_i;
    assign bus.m1_rdata_o  = bus.s_rdata_i;
    assign bus.err_o       = err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            last_gnt <= 1'b1;
            err      <= 1'b0;
        end else begin
            if (push) begin
                owner[wr_ptr] <= winner;
                wr_ptr        <= next_ptr(wr_ptr);
                last_gnt      <= winner;
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.s_rvalid_i && empty) begin
                err <= 1'b1;
            end
        end
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: maximum outstanding transactions tracked; integer, 1 to 8.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset; asynchronous, active-high.
REQ-004 mN_req_i  input  1  master N request (N=0 core LSU, N=1 DMA); held high until granted.
REQ-005 mN_we_i  input  1  master N write enable.
REQ-006 mN_be_i  input  4  master N byte enables.
REQ-007 mN_addr_i  input  32  master N byte address.
REQ-008 mN_wdata_i  input  32  master N write data.
REQ-009 mN_gnt_o  output  1  master N request accepted this cycle.
REQ-010 mN_rvalid_o  output  1  response for master N valid this cycle.
REQ-011 mN_rdata_o  output  32  read data to master N.
REQ-012 s_req_o, s_we_o, s_be_o[3:0], s_addr_o[31:0], s_wdata_o[31:0]  output  request to the shared peripheral bus.
REQ-013 s_gnt_i  input  1  bus accepts request.
REQ-014 s_rvalid_i  input  1  bus response valid.
REQ-015 s_rdata_i  input  32  bus read data.
REQ-016 err_o  output  1  sticky flag: response received with no transaction outstanding.

Function
REQ-017 The winner is chosen combinationally each cycle:
- If exactly one master requests, that master wins.
- If both request, the master not named by the last-grant pointer wins (round-robin).
- If neither requests, master 0 is selected and s_req_o = 0.
REQ-018 s_req_o is high when any master requests and the owner FIFO is not full; s_req_o is forced low when the FIFO holds DEPTH entries.
REQ-019 s_we_o, s_be_o, s_addr_o and s_wdata_o equal the winner's inputs.
REQ-020 mN_gnt_o = s_req_o & s_gnt_i & (winner == N); at most one grant is issued per cycle.
REQ-021 Handshake = s_req_o & s_gnt_i. On a handshake:
- the winner ID is pushed into the owner FIFO;
- the last-grant pointer is set to the winner ID.
REQ-022 The pointer is unchanged in any cycle without a handshake, including cycles where requests are pending but the FIFO is full.
REQ-023 On s_rvalid_i with the FIFO non-empty:
- mN_rvalid_o = 1 for N equal to the FIFO head, combinationally;
- the head is popped at the clock edge.
REQ-024 mN_rdata_o = s_rdata_i for both masters at all times; the rdata of the non-selected master is don't-care.
REQ-025 If a push and a pop occur in the same cycle, the FIFO count is unchanged and the read and write pointers both advance; ordering is strictly preserved.
REQ-026 FIFO pointers wrap modulo DEPTH; the count ranges 0..DEPTH.
REQ-027 On s_rvalid_i with the FIFO empty:
- both mN_rvalid_o stay 0;
- err_o is set to 1 and holds until reset.
REQ-028 The losing master's request is not acknowledged; that master holds its request, and it wins the next tie because the pointer now names the other master.
REQ-029 Latency: zero added cycles on the request path and on the response path.

Reset
REQ-030 Assertion of rst_i at any time, including with transactions outstanding, immediately sets:
- FIFO empty (count 0, pointers 0);
- last-grant pointer = 1, so that master 0 wins the first tie;
- err_o = 0.
REQ-031 During reset, mN_gnt_o and mN_rvalid_o follow REQ-018 to REQ-023 with an empty FIFO: grants are possible, and rvalid outputs are 0.
REQ-032 Responses for transactions issued before reset are dropped and flag err_o once reset is released.

Verification
REQ-033 Single master: m0 writes 0xDEADBEEF to 0x00000010, be=4'hF, s_gnt_i=1 → m0_gnt_o=1 the same cycle and s_addr_o=0x00000010; rvalid returned on the next cycle → m0_rvalid_o=1, m1_rvalid_o=0.
REQ-034 Contention: both masters request continuously for 4 cycles after reset, s_gnt_i=1, responses one cycle later → grants ordered m0, m1, m0, m1; each rvalid routed to the master that issued the request.
REQ-035 Full FIFO (DEPTH=2): two reads granted with s_rvalid_i held low → s_req_o=0 and no gnt on the third cycle; a single rvalid then frees a slot, and the grant is issued on the following cycle.
REQ-036 Simultaneous push and pop: count=1 (owner m1); m0 is granted in the same cycle as rvalid → m1_rvalid_o=1 that cycle; the FIFO head becomes m0 and count stays 1.
REQ-037 Spurious response: s_rvalid_i=1 with the FIFO empty → both rvalid outputs 0 and err_o=1 from the next cycle, persisting until rst_i.
REQ-038 Mid-operation reset: rst_i pulsed with 2 entries outstanding → FIFO empties immediately; the next tie is won by m0; a late rvalid sets err_o.
